// File: rtl/board_draw_ctrl.sv
// Incremental board renderer for the VGA adapter: snapshots the board, redraws only
// changed cells pixel by pixel, and pulses frame_done once each frame completes.
module board_draw_ctrl #(
    parameter int unsigned COLS      = 10,
    parameter int unsigned ROWS      = 20,
    parameter int unsigned CELL_W    = 6,
    parameter int unsigned CELL_H    = 6,
    parameter int unsigned X_ORIGIN  = 0,
    parameter int unsigned Y_ORIGIN  = 0,
    parameter logic [2:0]  FG_COLOUR = 3'b001,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [COLS*ROWS-1:0] board,
    input  logic                 board_valid,
    input  logic                 force_full,
    input  logic                 hold,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
);

    localparam int unsigned NCell = COLS * ROWS;
    localparam int unsigned IdxW  = $clog2(NCell);
    localparam int unsigned ColW  = $clog2(COLS + 1);
    localparam int unsigned SxW   = $clog2(CELL_W + 1);
    localparam int unsigned SyW   = $clog2(CELL_H + 1);

    typedef enum logic [2:0] {StIdle, StSnap, StScan, StDraw, StDone} state_e;

    state_e             state_q;
    logic [NCell-1:0]   shadow_q, snap_q, dirty_q;
    logic               full_q, first_q;
    logic [IdxW-1:0]    idx_q;
    logic [ColW-1:0]    col_q;
    logic [7:0]         xbase_q;
    logic [6:0]         ybase_q;
    logic [SxW-1:0]     sx_q;
    logic [SyW-1:0]     sy_q;
    logic [7:0]         x_q;
    logic [6:0]         y_q;
    logic [2:0]         colour_q;
    logic               plot_q;

    logic               last_cell, col_wrap, sx_last, sy_last, advance;

    assign last_cell = (idx_q == IdxW'(NCell - 1));
    assign col_wrap  = (col_q == ColW'(COLS - 1));
    assign sx_last   = (sx_q == SxW'(CELL_W - 1));
    assign sy_last   = (sy_q == SyW'(CELL_H - 1));

    // A cell is finished either when it is clean in SCAN or after its last pixel in DRAW.
    always_comb begin
        advance = 1'b0;
        if (!hold) begin
            if (state_q == StScan && !dirty_q[idx_q]) advance = 1'b1;
            if (state_q == StDraw && sx_last && sy_last) advance = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            snap_q   <= '0;
            dirty_q  <= '0;
            full_q   <= 1'b0;
            first_q  <= 1'b1;
            idx_q    <= '0;
            col_q    <= '0;
            xbase_q  <= 8'(X_ORIGIN);
            ybase_q  <= 7'(Y_ORIGIN);
            sx_q     <= '0;
            sy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (board_valid && (board != shadow_q || force_full || first_q)) begin
                        full_q  <= force_full || first_q;
                        state_q <= StSnap;
                    end
                end
                StSnap: begin
                    snap_q  <= board;
                    dirty_q <= full_q ? '1 : (board ^ shadow_q);
                    first_q <= 1'b0;
                    idx_q   <= '0;
                    col_q   <= '0;
                    xbase_q <= 8'(X_ORIGIN);
                    ybase_q <= 7'(Y_ORIGIN);
                    state_q <= StScan;
                end
                StScan: begin
                    if (!hold && dirty_q[idx_q]) begin
                        sx_q    <= '0;
                        sy_q    <= '0;
                        state_q <= StDraw;
                    end
                end
                StDraw: begin
                    if (!hold) begin
                        x_q      <= xbase_q + 8'(sx_q);
                        y_q      <= ybase_q + 7'(sy_q);
                        colour_q <= snap_q[idx_q] ? FG_COLOUR : BG_COLOUR;
                        plot_q   <= 1'b1;
                        if (sx_last) begin
                            sx_q <= '0;
                            if (sy_last) shadow_q[idx_q] <= snap_q[idx_q];
                            else         sy_q <= sy_q + 1'b1;
                        end else begin
                            sx_q <= sx_q + 1'b1;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // Running base counters replace col*CELL_W / row*CELL_H products.
            if (advance) begin
                idx_q <= idx_q + 1'b1;
                if (col_wrap) begin
                    col_q   <= '0;
                    xbase_q <= 8'(X_ORIGIN);
                    ybase_q <= ybase_q + 7'(CELL_H);
                end else begin
                    col_q   <= col_q + 1'b1;
                    xbase_q <= xbase_q + 8'(CELL_W);
                end
                state_q <= last_cell ? StDone : StScan;
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Randomised bench for board_draw_ctrl: a frame-level reference model predicts every
// output each cycle, and literal totals pin the model on the directed scenarios.
module tb_board_draw_ctrl;

    localparam int NC = 200;

    logic          clk;
    logic          resetn, board_valid, force_full, hold;
    logic [NC-1:0] board;
    logic          busy, frame_done, plot;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;

    board_draw_ctrl dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .board      (board),
        .board_valid(board_valid),
        .force_full (force_full),
        .hold       (hold),
        .busy       (busy),
        .frame_done (frame_done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a list of steps (SNAP, per cell SCAN + 36 pixels, DONE).
    bit          m_valid = 0;
    bit          m_busy, m_first, m_full;
    bit [NC-1:0] m_shadow, m_snap;
    int          m_pos, m_len;
    int          sched[$];
    bit          e_busy, e_done, e_plot;
    int          e_x, e_y, e_c;

    // Frame statistics observed on the DUT.
    int st_len, st_plots, st_fg, st_done, st_minx, st_maxx, st_miny, st_maxy;

    task automatic clear_stats();
        st_len = 0; st_plots = 0; st_fg = 0; st_done = 0;
        st_minx = 255; st_maxx = 0; st_miny = 127; st_maxy = 0;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic build_schedule();
        bit [NC-1:0] dirty;
        m_snap = board;
        dirty  = m_full ? {NC{1'b1}} : (board ^ m_shadow);
        sched.delete();
        sched.push_back(-1);
        for (int idx = 0; idx < NC; idx++) begin
            sched.push_back(-1);
            if (dirty[idx]) begin
                for (int sy = 0; sy < 6; sy++)
                    for (int sx = 0; sx < 6; sx++)
                        sched.push_back(((idx % 10) * 6 + sx) | (((idx / 10) * 6 + sy) << 8) |
                                        ((m_snap[idx] ? 1 : 0) << 16));
            end
        end
        sched.push_back(-1);
        m_len   = sched.size();
        m_first = 0;
    endtask

    // Predict the outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit stall;
        if (!resetn) begin
            m_valid = 1; m_busy = 0; m_shadow = '0; m_first = 1;
            e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_busy = 0; e_done = 0;
            return;
        end
        if (!m_valid) return;
        e_plot = 0;
        if (!m_busy) begin
            if (board_valid && (board != m_shadow || force_full || m_first)) begin
                m_busy = 1; m_pos = 0; m_full = force_full || m_first;
            end
        end else begin
            stall = hold && m_pos != 0 && m_pos != m_len - 1;
            if (m_pos == 0) build_schedule();
            if (!stall) begin
                if (sched[m_pos] >= 0) begin
                    e_plot = 1;
                    e_x = sched[m_pos] & 255;
                    e_y = (sched[m_pos] >> 8) & 127;
                    e_c = (sched[m_pos] >> 16) & 7;
                end
                m_pos++;
                if (m_pos == m_len) begin
                    m_busy   = 0;
                    m_shadow = m_snap;
                end
            end
        end
        e_busy = m_busy;
        e_done = m_busy && m_pos == m_len - 1;
    endtask

    task automatic check_outputs();
        logic [20:0] got, exp;
        if (!m_valid) return;
        got = {busy, frame_done, plot, x, y, colour};
        exp = {e_busy, e_done, e_plot, 8'(e_x), 7'(e_y), 3'(e_c)};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL cycle@%0t: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, expected busy=%b done=%b plot=%b x=%0d y=%0d c=%0d",
                         $time, busy, frame_done, plot, x, y, colour,
                         e_busy, e_done, e_plot, e_x, e_y, e_c);
        end
        if (busy === 1'b1) st_len++;
        if (frame_done === 1'b1) st_done++;
        if (plot === 1'b1) begin
            st_plots++;
            if (colour == 3'b001) st_fg++;
            if (int'(x) < st_minx) st_minx = x;
            if (int'(x) > st_maxx) st_maxx = x;
            if (int'(y) < st_miny) st_miny = y;
            if (int'(y) > st_maxy) st_maxy = y;
        end
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_frame(input int budget, input string name);
        int n = 0;
        while (st_done == 0 && n < budget) begin
            cyc();
            n++;
        end
        lit({name, "_done"}, st_done, 1);
    endtask

    task automatic wait_plots(input int target, input int budget);
        int n = 0;
        while (st_plots < target && n < budget) begin
            cyc();
            n++;
        end
        lit("plots_reached", st_plots, target);
    endtask

    initial begin
        int p0, fg_cells, n;
        resetn = 0; board = '0; board_valid = 1; force_full = 0; hold = 0;
        repeat (3) cyc();
        lit("reset_x", int'(x), 0);
        lit("reset_busy", int'(busy), 0);

        // T1: first frame after reset is a full background redraw.
        resetn = 1;
        clear_stats();
        wait_frame(8000, "t1");
        lit("t1_plots", st_plots, 7200);
        lit("t1_len", st_len, 7402);
        lit("t1_fg", st_fg, 0);
        cyc();

        // T2: a single changed cell.
        board[13] = 1'b1;
        clear_stats();
        wait_frame(400, "t2");
        lit("t2_plots", st_plots, 36);
        lit("t2_len", st_len, 238);
        lit("t2_fg", st_fg, 36);
        lit("t2_minx", st_minx, 18);
        lit("t2_maxx", st_maxx, 23);
        lit("t2_miny", st_miny, 6);
        lit("t2_maxy", st_maxy, 11);
        cyc();

        // T3: unchanged board never starts a frame.
        clear_stats();
        repeat (1000) cyc();
        lit("t3_len", st_len, 0);
        lit("t3_plots", st_plots, 0);
        lit("t3_done", st_done, 0);

        // T4: hold for 10 cycles in the middle of cell 13.
        board[13] = 1'b0;
        clear_stats();
        wait_plots(10, 400);
        p0   = st_plots;
        hold = 1;
        repeat (10) cyc();
        lit("t4_hold_plots", st_plots, p0);
        hold = 0;
        wait_frame(400, "t4");
        lit("t4_plots", st_plots, 36);
        lit("t4_len", st_len, 248);
        cyc();

        // T5: reset mid-draw aborts and forces a full redraw.
        board[0] = 1'b1;
        clear_stats();
        wait_plots(5, 400);
        resetn = 0;
        cyc();
        lit("t5_plot", int'(plot), 0);
        lit("t5_busy", int'(busy), 0);
        resetn = 1;
        clear_stats();
        wait_frame(8000, "t5");
        lit("t5_plots", st_plots, 7200);
        lit("t5_fg", st_fg, 36);
        cyc();

        // T6: random board, then force_full on an unchanged board.
        for (int i = 0; i < NC; i++) board[i] = 1'($urandom_range(0, 1));
        fg_cells = $countones(board);
        clear_stats();
        wait_frame(8000, "t6a");
        cyc();
        force_full = 1;
        clear_stats();
        cyc();
        force_full = 0;
        wait_frame(8000, "t6");
        lit("t6_plots", st_plots, 7200);
        lit("t6_fg", st_fg, fg_cells * 36);
        lit("t6_len", st_len, 7402);
        cyc();
        clear_stats();
        repeat (50) cyc();
        lit("t6_shadow_kept", st_len, 0);

        // Random phase: sparse board edits, gaps in board_valid, hold bursts, rare resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) board[$urandom_range(0, NC - 1)] ^= 1'b1;
            board_valid = ($urandom_range(0, 3) != 0);
            hold        = ($urandom_range(0, 4) == 0);
            force_full  = ($urandom_range(0, 499) == 0);
            resetn      = ($urandom_range(0, 999) != 0);
            cyc();
        end
        resetn = 1; hold = 0; force_full = 0; board_valid = 0;
        n = 0;
        while (busy && n < 16000) begin
            cyc();
            n++;
        end
        lit("drain_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
